// File: rtl/lcd_dma_pkg.sv
// Shared types and limits for the LCD DMA frame-buffer fetch controller.
package lcd_dma_pkg;

  localparam int BURST_MAX  = 16;
  localparam int FIFO_DEPTH = 32;
  localparam int LEN_W      = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SPACE,
    S_REQ,
    S_DATA,
    S_DRAIN,
    S_ERR
  } fetch_state_t;

endpackage

// File: rtl/lcd_dma_fetch_ctrl_if.sv
// Single-outstanding burst read port: request/grant handshake plus read beat return channel.
interface lcd_dma_fetch_ctrl_if;
  import lcd_dma_pkg::*;

  logic             bus_req;
  logic [31:0]      bus_addr;
  logic [LEN_W-1:0] bus_len;
  logic             bus_gnt;
  logic             bus_rvalid;
  logic [31:0]      bus_rdata;
  logic             bus_rlast;
  logic             bus_err;

  modport master (
    output bus_req, bus_addr, bus_len,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_rlast, bus_err
  );

  modport slave (
    input  bus_req, bus_addr, bus_len,
    output bus_gnt, bus_rvalid, bus_rdata, bus_rlast, bus_err
  );

endinterface

// File: rtl/lcd_dma_addr_gen.sv
// Frame address / remaining-word counters; next burst length is min(BURST, remaining).
// Load and per-beat update take effect on the next edge; no backpressure of its own.
module lcd_dma_addr_gen
  import lcd_dma_pkg::*;
#(
  parameter int BURST    = 8,
  parameter int FWORDS_W = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [31:0]         i_base,
  input  logic [FWORDS_W-1:0] i_words,
  input  logic                i_beat,
  output logic [31:0]         o_addr,
  output logic [FWORDS_W-1:0] o_rem,
  output logic [LEN_W-1:0]    o_next_len
);

  logic [31:0]         r_addr;
  logic [FWORDS_W-1:0] r_rem;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_addr <= i_base & 32'hFFFF_FFFC;
      r_rem  <= i_words;
    end else if (i_beat && (r_rem != '0)) begin
      // Address wraps modulo 2^32 by construction.
      r_addr <= r_addr + 32'd4;
      r_rem  <= r_rem - FWORDS_W'(1);
    end
  end

  assign o_addr     = r_addr;
  assign o_rem      = r_rem;
  assign o_next_len = (r_rem >= FWORDS_W'(BURST)) ? LEN_W'(BURST) : LEN_W'(r_rem);

endmodule

// File: rtl/lcd_dma_fetch_ctrl.sv
// Fills the LCD DMA FIFO with frame-buffer bursts; restarts the frame on every fp_pulse.
// Beat-to-push latency 1 cycle; a burst is requested only when the FIFO has room for all of it.
module lcd_dma_fetch_ctrl
  import lcd_dma_pkg::*;
#(
  parameter int BURST      = 8,
  parameter int FWORDS_W   = 20,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [31:0]           fb_base,
  input  logic [FWORDS_W-1:0]   frame_words,
  input  logic                  fp_pulse,
  input  logic [5:0]            depth_left,
  lcd_dma_fetch_ctrl_if.master  bus,
  output logic                  fifo_push,
  output logic [31:0]           fifo_wdata,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_irq
);

  fetch_state_t r_state, w_state_nxt;
  logic r_stale, w_stale_nxt;
  logic r_in_burst;
  logic r_bus_req;
  logic [31:0] r_bus_addr;
  logic [LEN_W-1:0] r_bus_len;
  logic r_fifo_push, r_frame_done, r_err_irq;
  logic [31:0] r_fifo_wdata;

  logic w_load, w_dec, w_push, w_done, w_issue, w_err_set;
  logic w_beat, w_last, w_restart;
  logic [31:0] w_addr;
  logic [FWORDS_W-1:0] w_rem;
  logic [LEN_W-1:0] w_next_len;

  lcd_dma_addr_gen #(.BURST(BURST), .FWORDS_W(FWORDS_W)) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_base     (fb_base),
    .i_words    (frame_words),
    .i_beat     (w_dec),
    .o_addr     (w_addr),
    .o_rem      (w_rem),
    .o_next_len (w_next_len)
  );

  assign w_beat    = bus.bus_rvalid;
  assign w_last    = bus.bus_rvalid & bus.bus_rlast;
  assign w_restart = fp_pulse & enable & (frame_words != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_stale_nxt = 1'b0;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_push      = 1'b0;
    w_done      = 1'b0;
    w_issue     = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_restart) begin
          w_load      = 1'b1;
          w_state_nxt = S_WAIT_SPACE;
        end
      end
      S_WAIT_SPACE: begin
        // A reload here is re-qualified by enable/frame_words on the following cycle.
        if (fp_pulse) begin
          w_load = 1'b1;
        end else if (!enable || (w_rem == '0)) begin
          w_state_nxt = S_IDLE;
        end else if (depth_left >= {1'b0, w_next_len}) begin
          w_issue     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // The request cannot be withdrawn; a frame restart marks its data as stale.
        w_stale_nxt = r_stale | fp_pulse;
        w_load      = fp_pulse;
        if (bus.bus_gnt) begin
          w_stale_nxt = 1'b0;
          w_state_nxt = (r_stale | fp_pulse) ? S_DRAIN : S_DATA;
        end
      end
      S_DATA: begin
        if (fp_pulse) begin
          w_load      = 1'b1;
          w_err_set   = w_beat & bus.bus_err;
          w_state_nxt = w_last ? S_WAIT_SPACE : S_DRAIN;
        end else if (w_beat && bus.bus_err) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_ERR;
        end else if (w_beat) begin
          w_push = 1'b1;
          w_dec  = 1'b1;
          if (w_last) begin
            if (w_rem == FWORDS_W'(1)) begin
              w_done      = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = enable ? S_WAIT_SPACE : S_IDLE;
            end
          end
        end
      end
      S_DRAIN: begin
        w_load = fp_pulse;
        if (w_beat && bus.bus_err) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_ERR;
        end else if (w_last) begin
          w_state_nxt = S_WAIT_SPACE;
        end
      end
      S_ERR: begin
        if (!r_in_burst || w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_stale      <= 1'b0;
      r_in_burst   <= 1'b0;
      r_bus_req    <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_len    <= '0;
      r_fifo_push  <= 1'b0;
      r_fifo_wdata <= '0;
      r_frame_done <= 1'b0;
      r_err_irq    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stale <= w_stale_nxt;
      if (r_state == S_REQ && bus.bus_gnt) r_in_burst <= 1'b1;
      else if (w_last)                     r_in_burst <= 1'b0;
      if (w_issue) begin
        r_bus_req  <= 1'b1;
        r_bus_addr <= w_addr;
        r_bus_len  <= w_next_len;
      end else if (r_state == S_REQ && bus.bus_gnt) begin
        r_bus_req <= 1'b0;
      end
      r_fifo_push <= w_push;
      if (w_push) r_fifo_wdata <= bus.bus_rdata;
      r_frame_done <= w_done;
      if (w_err_set)     r_err_irq <= 1'b1;
      else if (fp_pulse) r_err_irq <= 1'b0;
    end
  end

  assign bus.bus_req  = r_bus_req;
  assign bus.bus_addr = r_bus_addr;
  assign bus.bus_len  = r_bus_len;
  assign fifo_push    = r_fifo_push;
  assign fifo_wdata   = r_fifo_wdata;
  assign busy         = (r_state != S_IDLE);
  assign frame_done   = r_frame_done;
  assign err_irq      = r_err_irq;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(fifo_push && depth_left == '0));
  a_depth_range: assert property (@(posedge clk) disable iff (!rst)
    depth_left <= 6'(FIFO_DEPTH));
  a_req_stable: assert property (@(posedge clk) disable iff (!rst)
    (bus.bus_req && !bus.bus_gnt) |=> (bus.bus_req && $stable(bus.bus_addr) && $stable(bus.bus_len)));
  a_len_range: assert property (@(posedge clk) disable iff (!rst)
    bus.bus_req |-> (bus.bus_len >= LEN_W'(1) && bus.bus_len <= LEN_W'(BURST) && BURST <= BURST_MAX));
  a_beat_expected: assert property (@(posedge clk) disable iff (!rst)
    bus.bus_rvalid |-> (r_state == S_DATA || r_state == S_DRAIN || r_state == S_ERR));

endmodule

// File: tb/tb_lcd_dma_fetch_ctrl.sv
// Directed bench for lcd_dma_fetch_ctrl: acts as bus slave and checks requests, pushes and flags.
module tb_lcd_dma_fetch_ctrl;
  import lcd_dma_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] fb_base;
  logic [19:0] frame_words;
  logic        fp_pulse;
  logic [5:0]  depth_left;
  logic        fifo_push;
  logic [31:0] fifo_wdata;
  logic        busy;
  logic        frame_done;
  logic        err_irq;

  int n_checks = 0;
  int n_errs   = 0;

  lcd_dma_fetch_ctrl_if bus_if ();

  lcd_dma_fetch_ctrl #(.BURST(8), .FWORDS_W(20), .FIFO_DEPTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .fb_base     (fb_base),
    .frame_words (frame_words),
    .fp_pulse    (fp_pulse),
    .depth_left  (depth_left),
    .bus         (bus_if.master),
    .fifo_push   (fifo_push),
    .fifo_wdata  (fifo_wdata),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_irq     (err_irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!bus_if.bus_req && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_req"}, 32'(bus_if.bus_req), 32'd1);
  endtask

  task automatic grant();
    bus_if.bus_gnt = 1'b1;
    tick();
    bus_if.bus_gnt = 1'b0;
  endtask

  // Presents n beats; err_at / fp_at pick the beat carrying bus_err / fp_pulse (-1 = none).
  task automatic serve_burst(input int n, input int err_at, input int fp_at, input logic [31:0] dbase,
                             output int pushes, output int bad, output int dones);
    pushes = 0;
    bad    = 0;
    dones  = 0;
    for (int i = 0; i < n; i++) begin
      bus_if.bus_rvalid = 1'b1;
      bus_if.bus_rdata  = dbase + 32'(i);
      bus_if.bus_rlast  = (i == n - 1);
      bus_if.bus_err    = (i == err_at);
      fp_pulse          = (i == fp_at);
      tick();
      fp_pulse = 1'b0;
      if (fifo_push) begin
        pushes++;
        if (fifo_wdata !== dbase + 32'(i)) bad++;
      end
      if (frame_done) begin
        dones++;
        if (!fifo_push) bad++;
      end
    end
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rlast  = 1'b0;
    bus_if.bus_err    = 1'b0;
  endtask

  task automatic start_frame(input logic [31:0] base, input logic [19:0] words);
    fb_base     = base;
    frame_words = words;
    fp_pulse    = 1'b1;
    tick();
    fp_pulse = 1'b0;
  endtask

  initial begin
    int p, b, d, cnt;
    rst = 1'b0; enable = 1'b0; fb_base = '0; frame_words = '0; fp_pulse = 1'b0; depth_left = 6'd32;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
    bus_if.bus_rlast = 1'b0; bus_if.bus_err = 1'b0;
    tick();
    tick();
    check_eq("rst_req",  32'(bus_if.bus_req), 32'd0);
    check_eq("rst_addr", bus_if.bus_addr, 32'd0);
    check_eq("rst_len",  32'(bus_if.bus_len), 32'd0);
    check_eq("rst_push", 32'(fifo_push), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err",  32'(err_irq), 32'd0);
    rst = 1'b1;
    enable = 1'b1;

    // 1: 16 words, two full bursts
    start_frame(32'h0000_1000, 20'd16);
    check_eq("t1_busy", 32'(busy), 32'd1);
    wait_req("t1_b0");
    check_eq("t1_addr0", bus_if.bus_addr, 32'h0000_1000);
    check_eq("t1_len0",  32'(bus_if.bus_len), 32'd8);
    grant();
    check_eq("t1_req_drop", 32'(bus_if.bus_req), 32'd0);
    serve_burst(8, -1, -1, 32'hA000_0000, p, b, d);
    check_eq("t1_push0", 32'(p), 32'd8);
    check_eq("t1_bad0",  32'(b), 32'd0);
    check_eq("t1_done0", 32'(d), 32'd0);
    wait_req("t1_b1");
    check_eq("t1_addr1", bus_if.bus_addr, 32'h0000_1020);
    check_eq("t1_len1",  32'(bus_if.bus_len), 32'd8);
    grant();
    serve_burst(8, -1, -1, 32'hA000_0100, p, b, d);
    check_eq("t1_push1", 32'(p), 32'd8);
    check_eq("t1_bad1",  32'(b), 32'd0);
    check_eq("t1_done1", 32'(d), 32'd1);
    check_eq("t1_done_last", 32'(frame_done), 32'd1);
    check_eq("t1_idle", 32'(busy), 32'd0);
    tick();
    check_eq("t1_done_pulse", 32'(frame_done), 32'd0);

    // 2: 13 words -> 8 + 5, no zero-length request
    start_frame(32'h0000_2000, 20'd13);
    wait_req("t2_b0");
    check_eq("t2_addr0", bus_if.bus_addr, 32'h0000_2000);
    check_eq("t2_len0",  32'(bus_if.bus_len), 32'd8);
    grant();
    serve_burst(8, -1, -1, 32'hB000_0000, p, b, d);
    check_eq("t2_push0", 32'(p), 32'd8);
    wait_req("t2_b1");
    check_eq("t2_addr1", bus_if.bus_addr, 32'h0000_2020);
    check_eq("t2_len1",  32'(bus_if.bus_len), 32'd5);
    grant();
    serve_burst(5, -1, -1, 32'hB000_0100, p, b, d);
    check_eq("t2_push1", 32'(p), 32'd5);
    check_eq("t2_done1", 32'(d), 32'd1);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus_if.bus_req || busy) cnt++;
    end
    check_eq("t2_no_len0", 32'(cnt), 32'd0);

    // 3: insufficient FIFO space holds off the request
    depth_left = 6'd5;
    start_frame(32'h0000_3000, 20'd16);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus_if.bus_req) cnt++;
    end
    check_eq("t3_hold", 32'(cnt), 32'd0);
    depth_left = 6'd8;
    tick();
    check_eq("t3_req", 32'(bus_if.bus_req), 32'd1);
    check_eq("t3_addr", bus_if.bus_addr, 32'h0000_3000);
    enable = 1'b0;
    grant();
    serve_burst(8, -1, -1, 32'hC000_0000, p, b, d);
    check_eq("t3_push", 32'(p), 32'd8);
    check_eq("t3_stop", 32'(busy), 32'd0);
    depth_left = 6'd32;
    enable = 1'b1;

    // 4: frame restart in the middle of a burst
    start_frame(32'h0000_4000, 20'd16);
    wait_req("t4_b0");
    grant();
    fb_base = 32'h0000_4000;
    serve_burst(8, -1, 3, 32'hD000_0000, p, b, d);
    check_eq("t4_push", 32'(p), 32'd3);
    check_eq("t4_bad",  32'(b), 32'd0);
    check_eq("t4_nodone", 32'(d), 32'd0);
    wait_req("t4_re");
    check_eq("t4_addr", bus_if.bus_addr, 32'h0000_4000);
    check_eq("t4_len",  32'(bus_if.bus_len), 32'd8);
    enable = 1'b0;
    grant();
    serve_burst(8, -1, -1, 32'hD000_0100, p, b, d);
    check_eq("t4_push2", 32'(p), 32'd8);
    check_eq("t4_nodone2", 32'(d), 32'd0);
    check_eq("t4_idle", 32'(busy), 32'd0);
    enable = 1'b1;

    // 5: bus error on second beat
    start_frame(32'h0000_5000, 20'd16);
    wait_req("t5_b0");
    grant();
    serve_burst(8, 1, -1, 32'hE000_0000, p, b, d);
    check_eq("t5_push", 32'(p), 32'd1);
    check_eq("t5_err",  32'(err_irq), 32'd1);
    check_eq("t5_idle", 32'(busy), 32'd0);
    tick();
    tick();
    check_eq("t5_sticky", 32'(err_irq), 32'd1);
    enable = 1'b0;
    start_frame(32'h0000_5000, 20'd16);
    check_eq("t5_clear", 32'(err_irq), 32'd0);
    check_eq("t5_stay_idle", 32'(busy), 32'd0);
    enable = 1'b1;

    // 6: reset in the middle of a burst
    start_frame(32'h0000_6000, 20'd16);
    wait_req("t6_b0");
    grant();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      bus_if.bus_rvalid = 1'b1;
      bus_if.bus_rdata  = 32'hF000_0000 + 32'(i);
      bus_if.bus_rlast  = (i == 7);
      if (i == 3) rst = 1'b0;
      tick();
      if (i < 3 && fifo_push) cnt++;
      if (i == 3) begin
        check_eq("t6_push0", 32'(fifo_push), 32'd0);
        check_eq("t6_wdata0", fifo_wdata, 32'd0);
        check_eq("t6_busy0", 32'(busy), 32'd0);
        check_eq("t6_req0", 32'(bus_if.bus_req), 32'd0);
      end
      if (i > 3 && fifo_push) cnt = cnt + 100;
    end
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rlast  = 1'b0;
    check_eq("t6_pushes", 32'(cnt), 32'd3);
    rst = 1'b1;
    tick();
    check_eq("t6_idle", 32'(busy), 32'd0);
    check_eq("t6_done", 32'(frame_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
